// File: rtl/facto_pkg.sv
// ============================================================================
// Module      : facto_pkg
// Description : Shared definitions for the FactoCore bus master: register map,
//               address windows and the host sequencer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package facto_pkg;

    // FactoCore register window; every other bus address decodes to RAM
    localparam logic [15:0] FACTO_BASE   = 16'h7000;
    localparam logic [15:0] FACTO_LAST   = 16'h70FF;
    localparam logic [15:0] RAM_BASE     = 16'h0000;
    localparam logic [15:0] RAM_LAST     = 16'hFFFF;

    localparam logic [7:0]  OFF_OPSTART  = 8'h00;
    localparam logic [7:0]  OFF_OPCLEAR  = 8'h08;
    localparam logic [7:0]  OFF_INTREN   = 8'h18;
    localparam logic [7:0]  OFF_OPERAND  = 8'h20;
    localparam logic [7:0]  OFF_RESULT_H = 8'h28;
    localparam logic [7:0]  OFF_RESULT_L = 8'h30;

    localparam int unsigned TO_W = 16;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_REQ_A    = 4'd1,
        S_WR_OPND  = 4'd2,
        S_WR_IEN   = 4'd3,
        S_WR_START = 4'd4,
        S_WAIT_IRQ = 4'd5,
        S_REQ_B    = 4'd6,
        S_RD_H     = 4'd7,
        S_CAP_H    = 4'd8,
        S_RD_L     = 4'd9,
        S_CAP_L    = 4'd10,
        S_WR_MH    = 4'd11,
        S_WR_ML    = 4'd12,
        S_WR_CLR   = 4'd13,
        S_FIN      = 4'd14
    } state_e;

    function automatic logic [15:0] facto_reg(input logic [7:0] off);
        return FACTO_BASE + {8'h00, off};
    endfunction

endpackage

`default_nettype wire

// File: rtl/facto_host_timeout.sv
// ============================================================================
// Module      : facto_host_timeout
// Description : Loadable down-counter; expired_o flags the last enabled cycle
//               of a loaded interval. A load value of zero never expires.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module facto_host_timeout #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] value_i,
    input  logic             en_i,
    output logic             expired_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = value_i;
        end else if (en_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = en_i && !load_i && (count_q == WIDTH'(1));

endmodule

`default_nettype wire

// File: rtl/facto_host.sv
// ============================================================================
// Module      : facto_host
// Description : Bus-master sequencer that programs FactoCore for one factorial
//               job, waits for its interrupt, and stores the result to RAM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module facto_host
    import facto_pkg::*;
#(
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [63:0] cmd_n,
    input  logic [15:0] cmd_dst,
    output logic        m_req,
    input  logic        m_grant,
    output logic        m_wr,
    output logic [15:0] m_addr,
    output logic [63:0] m_dout,
    input  logic [63:0] m_din,
    input  logic        interrupt,
    output logic        done,
    output logic        error,
    output logic [63:0] res_hi,
    output logic [63:0] res_lo
);

    localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT);

    state_e      state_q, state_d;
    logic [63:0] n_q, n_d;
    logic [15:0] dst_q, dst_d;
    logic        err_q, err_d;
    logic [63:0] res_hi_q, res_hi_d;
    logic [63:0] res_lo_q, res_lo_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        done_q, done_d;
    logic        req_q, req_d;
    logic        wr_q, wr_d;
    logic [15:0] addr_q, addr_d;
    logic [63:0] dout_q, dout_d;
    logic        to_load, to_en, to_expired;

    assign to_en = (state_q == S_WAIT_IRQ);

    facto_host_timeout #(
        .WIDTH (TO_W)
    ) u_timeout (
        .clk_i     (clk),
        .reset_ni  (reset_n),
        .load_i    (to_load),
        .value_i   (TO_LOAD),
        .en_i      (to_en),
        .expired_o (to_expired)
    );

    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        dst_d    = dst_q;
        err_d    = err_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        to_load  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_d = S_REQ_A;
                    n_d     = cmd_n;
                    dst_d   = cmd_dst;
                    err_d   = 1'b0;
                end
            end
            S_REQ_A:    if (m_grant) state_d = S_WR_OPND;
            S_WR_OPND:  if (m_grant) state_d = S_WR_IEN;
            S_WR_IEN:   if (m_grant) state_d = S_WR_START;
            S_WR_START: begin
                if (m_grant) begin
                    state_d = S_WAIT_IRQ;
                    to_load = 1'b1;
                end
            end
            S_WAIT_IRQ: begin
                if (interrupt) begin
                    state_d = S_REQ_B;
                end else if (to_expired) begin
                    state_d = S_REQ_B;
                    err_d   = 1'b1;
                end
            end
            // An aborted job only needs the core cleared
            S_REQ_B:    if (m_grant) state_d = err_q ? S_WR_CLR : S_RD_H;
            S_RD_H:     if (m_grant) state_d = S_CAP_H;
            S_CAP_H: begin
                res_hi_d = m_din;
                state_d  = S_RD_L;
            end
            S_RD_L:     if (m_grant) state_d = S_CAP_L;
            S_CAP_L: begin
                res_lo_d = m_din;
                state_d  = S_WR_MH;
            end
            S_WR_MH:    if (m_grant) state_d = S_WR_ML;
            S_WR_ML:    if (m_grant) state_d = S_WR_CLR;
            S_WR_CLR:   if (m_grant) state_d = S_FIN;
            S_FIN:      state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Bus outputs are registered from the next state so they are valid for
    // the whole cycle the FSM spends in a state, and hold through stalls.
    always_comb begin
        cmd_ready_d = (state_d == S_IDLE);
        done_d      = (state_d == S_FIN);
        req_d       = 1'b0;
        wr_d        = 1'b0;
        addr_d      = '0;
        dout_d      = '0;
        unique case (state_d)
            S_REQ_A, S_REQ_B: req_d = 1'b1;
            S_WR_OPND: begin
                req_d = 1'b1; wr_d = 1'b1; addr_d = facto_reg(OFF_OPERAND); dout_d = n_d;
            end
            S_WR_IEN: begin
                req_d = 1'b1; wr_d = 1'b1; addr_d = facto_reg(OFF_INTREN); dout_d = 64'd1;
            end
            S_WR_START: begin
                req_d = 1'b1; wr_d = 1'b1; addr_d = facto_reg(OFF_OPSTART); dout_d = 64'd1;
            end
            S_RD_H, S_CAP_H: begin
                req_d = 1'b1; addr_d = facto_reg(OFF_RESULT_H);
            end
            S_RD_L, S_CAP_L: begin
                req_d = 1'b1; addr_d = facto_reg(OFF_RESULT_L);
            end
            S_WR_MH: begin
                req_d = 1'b1; wr_d = 1'b1; addr_d = dst_d; dout_d = res_hi_d;
            end
            S_WR_ML: begin
                req_d = 1'b1; wr_d = 1'b1; addr_d = dst_d + 16'd8; dout_d = res_lo_d;
            end
            S_WR_CLR: begin
                req_d = 1'b1; wr_d = 1'b1; addr_d = facto_reg(OFF_OPCLEAR); dout_d = 64'd1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            n_q         <= '0;
            dst_q       <= '0;
            err_q       <= 1'b0;
            res_hi_q    <= '0;
            res_lo_q    <= '0;
            cmd_ready_q <= 1'b1;
            done_q      <= 1'b0;
            req_q       <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            dout_q      <= '0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            dst_q       <= dst_d;
            err_q       <= err_d;
            res_hi_q    <= res_hi_d;
            res_lo_q    <= res_lo_d;
            cmd_ready_q <= cmd_ready_d;
            done_q      <= done_d;
            req_q       <= req_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            dout_q      <= dout_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign done      = done_q;
    assign error     = err_q;
    assign res_hi    = res_hi_q;
    assign res_lo    = res_lo_q;
    assign m_req     = req_q;
    assign m_wr      = wr_q;
    assign m_addr    = addr_q;
    assign m_dout    = dout_q;

endmodule

`default_nettype wire

// File: tb/tb_facto_host.sv
// ============================================================================
// Module      : tb_facto_host
// Description : Self-checking bench for facto_host with a behavioural RAM and
//               FactoCore on the bus, table-driven plus random jobs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_facto_host;

    typedef struct {
        logic [63:0] n;
        logic [15:0] dst;
        int          w;
        int          gdelay;
        bit          drop;
        logic [63:0] exp_hi;
        logic [63:0] exp_lo;
        int          exp_lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid, cmd_ready;
    logic [63:0] cmd_n;
    logic [15:0] cmd_dst;
    logic        m_req, gnt, m_wr;
    logic [15:0] m_addr;
    logic [63:0] m_dout;
    logic [63:0] bus_din = 64'd0;
    logic        fc_irq, done, error;
    logic [63:0] res_hi, res_lo;

    logic        t_valid, t_ready, t_req, t_gnt, t_wr, t_irq, t_done, t_err;
    logic [63:0] t_n, t_dout, t_din, t_hi, t_lo;
    logic [15:0] t_dst, t_addr;

    int          n_vec, n_err;
    int          irq_w;
    logic [63:0] fc_op    = 64'd0;
    logic [127:0] fc_res  = 128'd0;
    logic        fc_armed = 1'b0;
    logic        fc_live  = 1'b0;
    int          fc_cnt   = 0;
    logic [63:0] ram [0:8191];
    int          ram_wr_cnt = 0;
    logic [79:0] wlog [$];
    logic [79:0] tlog [$];
    int          t_rd = 0;

    always #5 clk = ~clk;

    facto_host dut (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_n(cmd_n), .cmd_dst(cmd_dst), .m_req(m_req), .m_grant(gnt), .m_wr(m_wr),
        .m_addr(m_addr), .m_dout(m_dout), .m_din(bus_din), .interrupt(fc_irq),
        .done(done), .error(error), .res_hi(res_hi), .res_lo(res_lo)
    );

    facto_host #(.TIMEOUT(16)) u_to (
        .clk(clk), .reset_n(reset_n), .cmd_valid(t_valid), .cmd_ready(t_ready),
        .cmd_n(t_n), .cmd_dst(t_dst), .m_req(t_req), .m_grant(t_gnt), .m_wr(t_wr),
        .m_addr(t_addr), .m_dout(t_dout), .m_din(t_din), .interrupt(t_irq),
        .done(t_done), .error(t_err), .res_hi(t_hi), .res_lo(t_lo)
    );

    function automatic logic [127:0] fact128(input logic [63:0] n);
        logic [127:0] r;
        r = 128'd1;
        for (int i = 2; i <= 40 && 64'(i) <= n; i++) r = r * 128'(i);
        return r;
    endfunction

    assign fc_irq = fc_armed && fc_live && (fc_cnt == 0);

    // RAM and FactoCore behaviour: accesses only take effect with request and grant
    always @(posedge clk) begin
        if (fc_armed && fc_cnt > 0) fc_cnt <= fc_cnt - 1;
        if (m_req && gnt) begin
            if (m_wr) begin
                if (m_addr[15:8] == 8'h70) begin
                    wlog.push_back({m_addr, m_dout});
                    if (m_addr == 16'h7020) fc_op <= m_dout;
                    if (m_addr == 16'h7000 && m_dout[0]) begin
                        fc_res   <= fact128(fc_op);
                        fc_armed <= 1'b1;
                        fc_live  <= (irq_w != 0);
                        fc_cnt   <= (irq_w > 0) ? irq_w - 1 : 0;
                    end
                    if (m_addr == 16'h7008 && m_dout[0]) fc_armed <= 1'b0;
                end else begin
                    ram[m_addr[15:3]] <= m_dout;
                    ram_wr_cnt        <= ram_wr_cnt + 1;
                end
            end else begin
                if (m_addr == 16'h7028)      bus_din <= fc_res[127:64];
                else if (m_addr == 16'h7030) bus_din <= fc_res[63:0];
                else                         bus_din <= ram[m_addr[15:3]];
            end
        end
    end

    always @(posedge clk) begin
        if (t_req && t_gnt) begin
            if (t_wr) tlog.push_back({t_addr, t_dout});
            else if (t_addr[15:8] == 8'h70) t_rd <= t_rd + 1;
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Runs one job on the main DUT; returns at the cycle done is high
    task automatic run_job(input vec_t v, input bit hold, output int idle_wait);
        int gwait, drop_left, wbase, rbase, lat;
        bit dropped, seen;
        logic [15:0] d2;
        logic [79:0] exp_w [4];
        irq_w     = v.w;
        cmd_n     = v.n;
        cmd_dst   = v.dst;
        cmd_valid = 1'b1;
        idle_wait = 0;
        while (!cmd_ready && idle_wait < 8) begin
            tick;
            idle_wait++;
        end
        wbase = wlog.size();
        rbase = ram_wr_cnt;
        gnt   = (v.gdelay == 0);
        tick;
        if (!hold) cmd_valid = 1'b0;
        gwait = v.gdelay; drop_left = 0; dropped = 1'b0; seen = 1'b0; lat = 0;
        while (!seen && lat < 500) begin
            if (gwait > 0) begin
                gnt = 1'b0;
                gwait--;
            end else if (drop_left > 0) begin
                gnt = 1'b0;
                drop_left--;
                chk("stall_req", 128'(m_req), 128'd1);
                chk("stall_addr", 128'(m_addr), 128'h7030);
            end else if (v.drop && !dropped && m_req && !m_wr && m_addr == 16'h7030) begin
                gnt       = 1'b0;
                dropped   = 1'b1;
                drop_left = 2;
            end else begin
                gnt = 1'b1;
            end
            tick;
            lat++;
            if (done) seen = 1'b1;
        end
        gnt = 1'b1;
        chk("latency", 128'(seen ? lat + 1 : -1), 128'(v.exp_lat));
        chk("res_hi", 128'(res_hi), 128'(v.exp_hi));
        chk("res_lo", 128'(res_lo), 128'(v.exp_lo));
        d2 = v.dst + 16'd8;
        chk("ram_hi", 128'(ram[v.dst[15:3]]), 128'(v.exp_hi));
        chk("ram_lo", 128'(ram[d2[15:3]]), 128'(v.exp_lo));
        chk("ram_writes", 128'(ram_wr_cnt - rbase), 128'd2);
        chk("core_writes", 128'(wlog.size() - wbase), 128'd4);
        exp_w[0] = {16'h7020, v.n};
        exp_w[1] = {16'h7018, 64'd1};
        exp_w[2] = {16'h7000, 64'd1};
        exp_w[3] = {16'h7008, 64'd1};
        if (wlog.size() >= wbase + 4)
            for (int k = 0; k < 4; k++) chk("core_wr_seq", 128'(wlog[wbase + k]), 128'(exp_w[k]));
    endtask

    initial begin
        vec_t v;
        vec_t vecs [$];
        int   iw, lat, tbase, rdbase;
        n_vec = 0; n_err = 0;
        reset_n = 1'b0; cmd_valid = 1'b0; cmd_n = '0; cmd_dst = '0; gnt = 1'b1; irq_w = 0;
        t_valid = 1'b0; t_n = '0; t_dst = '0; t_gnt = 1'b1; t_irq = 1'b0; t_din = '0;
        repeat (3) tick;
        chk("rst_cmd_ready", 128'(cmd_ready), 128'd1);
        chk("rst_m_req", 128'(m_req), 128'd0);
        chk("rst_bus", 128'({m_wr, m_addr, m_dout}), 128'd0);
        chk("rst_done_err", 128'({done, error}), 128'd0);
        chk("rst_res", 128'({res_hi, res_lo}), 128'd0);
        reset_n = 1'b1;
        tick;

        vecs.push_back('{64'd5,  16'h0040, 20, 0, 1'b0, 64'd0, 64'd120, 33});
        vecs.push_back('{64'd5,  16'h0040, 20, 7, 1'b1, 64'd0, 64'd120, 43});
        vecs.push_back('{64'd10, 16'hFFF8,  5, 0, 1'b0, 64'd0, 64'd3628800, 18});
        vecs.push_back('{64'd21, 16'h0100,  3, 2, 1'b0, 64'd2, 64'hC5077D36B8C40000, 18});
        vecs.push_back('{64'd0,  16'h0108,  1, 0, 1'b0, 64'd0, 64'd1, 14});
        for (int i = 0; i < 6; i++) begin
            v.n      = 64'($urandom_range(0, 34));
            v.dst    = 16'($urandom_range(0, 16'h0DFF) << 3);
            v.w      = int'($urandom_range(1, 40));
            v.gdelay = int'($urandom_range(0, 3));
            v.drop   = 1'b0;
            {v.exp_hi, v.exp_lo} = fact128(v.n);
            v.exp_lat = 13 + v.w + v.gdelay;
            vecs.push_back(v);
        end

        foreach (vecs[i]) begin
            run_job(vecs[i], 1'b0, iw);
            tick;
            chk("done_one_cycle", 128'(done), 128'd0);
            chk("ready_after_fin", 128'(cmd_ready), 128'd1);
        end
        chk("wrap_ram0", 128'(ram[0]), 128'd3628800);

        // cmd_valid held high across a job, then a back-to-back job
        v = '{64'd6, 16'h0300, 4, 0, 1'b0, 64'd0, 64'd720, 17};
        run_job(v, 1'b1, iw);
        v = '{64'd4, 16'h0310, 6, 0, 1'b0, 64'd0, 64'd24, 19};
        run_job(v, 1'b0, iw);
        chk("b2b_gap", 128'(iw), 128'd1);
        tick;
        chk("b2b_done_low", 128'(done), 128'd0);

        // Reset while waiting for an interrupt that never comes
        irq_w = 0; cmd_n = 64'd7; cmd_dst = 16'h0200; cmd_valid = 1'b1; gnt = 1'b1;
        tick;
        cmd_valid = 1'b0;
        repeat (8) tick;
        chk("waiting_bus_idle", 128'({m_req, m_wr}), 128'd0);
        reset_n = 1'b0;
        tick;
        chk("midrst_ready", 128'(cmd_ready), 128'd1);
        chk("midrst_bus", 128'({m_req, m_wr, m_addr, m_dout}), 128'd0);
        chk("midrst_res", 128'({res_hi, res_lo}), 128'd0);
        reset_n = 1'b1;
        tick;
        v = '{64'd3, 16'h0200, 9, 0, 1'b0, 64'd0, 64'd6, 22};
        run_job(v, 1'b0, iw);

        // Timeout on the TIMEOUT=16 instance with no interrupt
        tbase = tlog.size(); rdbase = t_rd;
        t_n = 64'd9; t_dst = 16'h0080; t_valid = 1'b1;
        tick;
        t_valid = 1'b0;
        lat = 0;
        while (!t_done && lat < 200) begin tick; lat++; end
        chk("to_latency", 128'(t_done ? lat + 1 : -1), 128'd23);
        chk("to_error", 128'(t_err), 128'd1);
        chk("to_writes", 128'(tlog.size() - tbase), 128'd4);
        if (tlog.size() >= tbase + 4) begin
            chk("to_opnd", 128'(tlog[tbase]), 128'({16'h7020, 64'd9}));
            chk("to_clr", 128'(tlog[tbase + 3]), 128'({16'h7008, 64'd1}));
        end
        chk("to_no_reads", 128'(t_rd - rdbase), 128'd0);
        chk("to_res", 128'({t_hi, t_lo}), 128'd0);
        tick;
        chk("to_done_low", 128'(t_done), 128'd0);
        chk("to_err_sticky", 128'(t_err), 128'd1);
        t_valid = 1'b1;
        tick;
        t_valid = 1'b0;
        chk("to_err_cleared", 128'(t_err), 128'd0);
        lat = 0;
        while (!t_done && lat < 200) begin tick; lat++; end
        chk("to_second_done", 128'(t_done), 128'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/facto_host.md
# facto_host

Bus-master sequencer that sits on the master side of the shared bus, the initiator end of the interface the bus arbitrates for RAM and FactoCore. It accepts one factorial job (operand plus RAM destination), programs FactoCore over the bus, and releases the bus while the core computes. On interrupt it reads the 128-bit result, stores it to RAM and clears the core. This replaces the testbench-driven master with synthesizable RTL.

## Interface
- FACTO_BASE, 16'h7000: FactoCore register base. Fixed offsets:
  - 0x00 opstart
  - 0x08 opclear
  - 0x18 intrEn
  - 0x20 operand
  - 0x28 result_h
  - 0x30 result_l
- TIMEOUT, 4096: max cycles in WAIT_IRQ before abort; 0 disables.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- cmd_valid  in  1  job request.
- cmd_ready  out  1  high only in IDLE.
- cmd_n  in  64  operand; captured when cmd_valid && cmd_ready.
- cmd_dst  in  16  RAM byte address, 8-byte aligned. Result_h goes to dst, result_l to dst+8.
- m_req  out  1  bus request.
- m_grant  in  1  bus grant from arbiter.
- m_wr  out  1  1 = write, 0 = read.
- m_addr  out  16  bus address.
- m_dout  out  64  write data.
- m_din  in  64  read data.
- interrupt  in  1  FactoCore completion, level.
- done  out  1  one-cycle pulse when a job finishes (ok or error).
- error  out  1  sticky timeout flag; cleared at the next accepted job.
- res_hi, res_lo  out  64 each  last result read; hold until the next read.

## Operation
- Reset values:
  - all outputs 0 except cmd_ready = 1
  - state IDLE, timeout counter 0
- FSM states: IDLE, REQ_A, WR_OPND, WR_IEN, WR_START, WAIT_IRQ, REQ_B, RD_H, CAP_H, RD_L, CAP_L, WR_MH, WR_ML, WR_CLR, FIN.
- IDLE → REQ_A on accepted job; latch cmd_n and cmd_dst.
- REQ_A: m_req = 1. Advance when m_grant = 1.
- Bus writes while granted:
  - WR_OPND: operand = n
  - WR_IEN: intrEn = 1
  - WR_START: opstart = 1
- After WR_START, drop m_req and go to WAIT_IRQ (bus released).
- WAIT_IRQ: interrupt = 1 → REQ_B.
  - Counter reaching TIMEOUT → set error; go to REQ_B with the read stages skipped, i.e. directly to WR_CLR once granted.
- REQ_B: m_req = 1, wait for m_grant.
- Reads: RD_H issues the result_h read; CAP_H latches m_din into res_hi. RD_L and CAP_L do the same for result_l into res_lo.
- RAM writes: WR_MH writes res_hi to dst; WR_ML writes res_lo to dst+8. 16-bit address add wraps modulo 2^16.
- WR_CLR: opclear = 1.
- FIN: m_req = 0, done = 1 for one cycle, back to IDLE.
- m_req is held continuously from grant to the end of each bus phase; never toggled mid-phase.
- If m_grant drops while a bus state is active, the FSM stalls: m_req stays 1, outputs hold, and the pending access re-issues when grant returns.
- cmd_valid during non-IDLE is ignored (cmd_ready = 0). No queueing.
- reset_n low at any cycle: the next edge forces IDLE with all outputs at reset values and any job discarded. FactoCore state is not cleared by this block.

## Timing
- Bus access happens in one cycle with m_grant high. A write completes in that cycle.
- Read: address is driven in RD_x; m_din is sampled in the following cycle (CAP_x), matching the synchronous RAM/FactoCore read latency.
- m_wr, m_addr and m_dout are registered. They are 0 when not in a bus state.
- Uncontended latency, accept to done:
  - REQ_A 1 + 3 writes
  - irq wait W
  - REQ_B 1 + 4 read cycles + 3 writes + FIN 1
  - total = 13 + W cycles
- interrupt is not sampled outside WAIT_IRQ. A stale level from a previous job is impossible because WR_CLR precedes IDLE.

## Structure
- Shared package facto_pkg:
  - FactoCore register offset constants
  - RAM/FactoCore address windows
  - FSM state enum
- One sub-module, facto_host_timeout: a loadable down-counter with an expiry flag, reused later by other masters.
- Bus-drive muxing stays in the top FSM.

## Test plan
- Grant is always 1, cmd_n = 5, cmd_dst = 0x0040, irq after 20 cycles → bus writes 0x7020 = 5, 0x7018 = 1, 0x7000 = 1; RAM[0x40] = 0, RAM[0x48] = 120; res_lo = 120; done at cycle 33.
- Grant delayed 7 cycles in REQ_A and dropped for 3 cycles mid-RD_L → no bus activity without grant; final RAM values unchanged.
- TIMEOUT = 16 with no interrupt → error = 1; only the opclear write occurs after release; done pulse; RAM untouched.
- cmd_dst = 0xFFF8 → second RAM write goes to address 0x0000 (wrap).
- reset_n low during WAIT_IRQ, then a new job with cmd_n = 3 → cmd_ready = 1 after reset; the second job completes with res_lo = 6.
- cmd_valid held high through a whole job → exactly one job accepted per IDLE visit; a back-to-back job starts the cycle after FIN.
